// File: rtl/rv32_csr_pkg.sv
// Shared definitions for the rv32 machine-mode trap/CSR unit:
// CSR addresses, mstatus/mie bit positions, cause codes and CSR op encoding.
package rv32_csr_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CSR_AW = 12;

    // CSR addresses
    localparam logic [CSR_AW-1:0] CSR_MSTATUS   = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MIE       = 12'h304;
    localparam logic [CSR_AW-1:0] CSR_MTVEC     = 12'h305;
    localparam logic [CSR_AW-1:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [CSR_AW-1:0] CSR_MEPC      = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE    = 12'h342;
    localparam logic [CSR_AW-1:0] CSR_MTVAL     = 12'h343;
    localparam logic [CSR_AW-1:0] CSR_MIP       = 12'h344;
    localparam logic [CSR_AW-1:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [CSR_AW-1:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [CSR_AW-1:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [CSR_AW-1:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [CSR_AW-1:0] CSR_MHARTID   = 12'hF14;

    // mstatus / mie / mip bit positions
    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MIP_MSI_BIT      = 3;
    localparam int unsigned MIP_MTI_BIT      = 7;
    localparam int unsigned MIP_MEI_BIT      = 11;
    localparam int unsigned MIP_LOCAL_BASE   = 16;

    // Interrupt cause codes
    localparam logic [4:0] IRQ_CAUSE_MSI = 5'd3;
    localparam logic [4:0] IRQ_CAUSE_MTI = 5'd7;
    localparam logic [4:0] IRQ_CAUSE_MEI = 5'd11;

    // Exception cause codes
    localparam logic [4:0] EXC_INSTR_MISALIGN = 5'd0;
    localparam logic [4:0] EXC_INSTR_FAULT    = 5'd1;
    localparam logic [4:0] EXC_ILLEGAL_INSTR  = 5'd2;
    localparam logic [4:0] EXC_BREAKPOINT     = 5'd3;
    localparam logic [4:0] EXC_LOAD_MISALIGN  = 5'd4;
    localparam logic [4:0] EXC_LOAD_FAULT     = 5'd5;
    localparam logic [4:0] EXC_STORE_MISALIGN = 5'd6;
    localparam logic [4:0] EXC_STORE_FAULT    = 5'd7;
    localparam logic [4:0] EXC_ECALL_M        = 5'd11;

    typedef enum logic [1:0] {
        CSR_OP_RSVD = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

endpackage

// File: rtl/rv32_csr_counter64.sv
// 64-bit CSR counter (mcycle / minstret).
// Ports: clk, rst_n (sync, active-low), inc_en_i (count this cycle),
//        wr_lo_i / wr_hi_i (replace a half with wdata_i), count_o (registered value).
// A write to either half suppresses the increment for the whole counter.
module rv32_csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_en_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    // Next value: halves written take priority over counting
    always_comb begin
        count_d = count_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) count_d[31:0]  = wdata_i;
            if (wr_hi_i) count_d[63:32] = wdata_i;
        end else if (inc_en_i) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/rv32_trap_csr_unit.sv
// Machine-mode trap/CSR unit: exceptions, prioritised interrupts, CSR RW/RS/RC
// access, mret, and 64-bit mcycle/minstret. Redirects fetch on trap and mret.
// Ports: clk, rst_n (sync, active-low); irq_software/timer/external, irq_local;
//        csr_req/op/addr/wdata -> csr_rdata, csr_illegal (combinational);
//        instr_commit, actual_pc, exc_valid/cause/tval, mret_commit;
//        take_trap/trap_pc, take_return/return_pc, irq_wake (combinational).
// Build option: RV32_MTVEC_VECTORED_EN enables mtvec vectored mode (MODE=01).
module rv32_trap_csr_unit
    import rv32_csr_pkg::*;
#(
    parameter int unsigned N_LOCAL_IRQ = 4,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_1000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               irq_software,
    input  logic                                               irq_timer,
    input  logic                                               irq_external,
    input  logic [((N_LOCAL_IRQ > 0) ? N_LOCAL_IRQ : 1)-1:0]   irq_local,
    input  logic                                               csr_req,
    input  logic [1:0]                                         csr_op,
    input  logic [11:0]                                        csr_addr,
    input  logic [31:0]                                        csr_wdata,
    output logic [31:0]                                        csr_rdata,
    output logic                                               csr_illegal,
    input  logic                                               instr_commit,
    input  logic [31:0]                                        actual_pc,
    input  logic                                               exc_valid,
    input  logic [4:0]                                         exc_cause,
    input  logic [31:0]                                        exc_tval,
    input  logic                                               mret_commit,
    output logic                                               take_trap,
    output logic [31:0]                                        trap_pc,
    output logic                                               take_return,
    output logic [31:0]                                        return_pc,
    output logic                                               irq_wake
);

    localparam logic [63:0] LOCAL_ONES = (64'd1 << N_LOCAL_IRQ) - 64'd1;
    localparam logic [31:0] MIE_WMASK  = 32'(LOCAL_ONES << MIP_LOCAL_BASE)
                                       | (32'd1 << MIP_MEI_BIT)
                                       | (32'd1 << MIP_MTI_BIT)
                                       | (32'd1 << MIP_MSI_BIT);

    csr_op_e     op;
    logic        mst_mie_q,  mst_mie_d;
    logic        mst_mpie_q, mst_mpie_d;
    logic [31:0] mie_q,      mie_d;
    logic [31:0] mtvec_q,    mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q,     mepc_d;
    logic [31:0] mcause_q,   mcause_d;
    logic [31:0] mtval_q,    mtval_d;
    logic [63:0] mcycle, minstret;

    logic [31:0] mip_c, irq_en, irq_pend;
    logic        irq_any;
    logic [4:0]  irq_cause;
    logic [31:0] mtvec_base;
    logic [31:0] csr_old, csr_new;
    logic        csr_known, csr_ro, csr_wr_attempt, csr_we;

    assign op = csr_op_e'(csr_op);

    // Live interrupt lines as seen in mip
    always_comb begin
        mip_c              = '0;
        mip_c[MIP_MSI_BIT] = irq_software;
        mip_c[MIP_MTI_BIT] = irq_timer;
        mip_c[MIP_MEI_BIT] = irq_external;
        for (int i = 0; i < int'(N_LOCAL_IRQ); i++) begin
            mip_c[MIP_LOCAL_BASE + i] = irq_local[i];
        end
    end

    assign irq_en   = mie_q & mip_c;
    assign irq_wake = |irq_en;
    assign irq_pend = mst_mie_q ? irq_en : 32'd0;
    assign irq_any  = |irq_pend;

    // Highest-priority pending cause: lowest priority assigned first, overridden upward
    always_comb begin
        irq_cause = '0;
        for (int i = int'(N_LOCAL_IRQ) - 1; i >= 0; i--) begin
            if (irq_pend[MIP_LOCAL_BASE + i]) irq_cause = 5'(MIP_LOCAL_BASE + i);
        end
        if (irq_pend[MIP_MSI_BIT]) irq_cause = IRQ_CAUSE_MSI;
        if (irq_pend[MIP_MTI_BIT]) irq_cause = IRQ_CAUSE_MTI;
        if (irq_pend[MIP_MEI_BIT]) irq_cause = IRQ_CAUSE_MEI;
    end

    assign take_trap   = instr_commit & (exc_valid | irq_any);
    assign take_return = instr_commit & mret_commit & ~take_trap;
    assign return_pc   = mepc_q;
    assign mtvec_base  = {mtvec_q[31:2], 2'b00};

`ifdef RV32_MTVEC_VECTORED_EN
    // Vectored mode offsets interrupts only; exceptions always use the base
    assign trap_pc = (mtvec_q[1:0] == 2'b01 && !exc_valid)
                   ? mtvec_base + {25'd0, irq_cause, 2'b00}
                   : mtvec_base;
`else
    assign trap_pc = mtvec_base;
`endif

    // CSR read mux and address classification
    always_comb begin
        csr_known = 1'b1;
        csr_ro    = 1'b0;
        csr_old   = '0;
        case (csr_addr)
            CSR_MSTATUS:   csr_old = 32'h0000_1800
                                   | (32'(mst_mpie_q) << MSTATUS_MPIE_BIT)
                                   | (32'(mst_mie_q)  << MSTATUS_MIE_BIT);
            CSR_MIE:       csr_old = mie_q;
            CSR_MTVEC:     csr_old = mtvec_q;
            CSR_MSCRATCH:  csr_old = mscratch_q;
            CSR_MEPC:      csr_old = mepc_q;
            CSR_MCAUSE:    csr_old = mcause_q;
            CSR_MTVAL:     csr_old = mtval_q;
            CSR_MIP:       begin csr_old = mip_c;   csr_ro = 1'b1; end
            CSR_MCYCLE:    csr_old = mcycle[31:0];
            CSR_MCYCLEH:   csr_old = mcycle[63:32];
            CSR_MINSTRET:  csr_old = minstret[31:0];
            CSR_MINSTRETH: csr_old = minstret[63:32];
            CSR_MHARTID:   begin csr_old = HART_ID; csr_ro = 1'b1; end
            default:       csr_known = 1'b0;
        endcase
    end

    // RS/RC with a zero operand is a pure read
    always_comb begin
        csr_new        = csr_old;
        csr_wr_attempt = 1'b0;
        case (op)
            CSR_OP_RW: begin csr_new = csr_wdata;            csr_wr_attempt = 1'b1; end
            CSR_OP_RS: begin csr_new = csr_old | csr_wdata;  csr_wr_attempt = |csr_wdata; end
            CSR_OP_RC: begin csr_new = csr_old & ~csr_wdata; csr_wr_attempt = |csr_wdata; end
            default:   ;
        endcase
    end

    assign csr_illegal = csr_req & ((op == CSR_OP_RSVD) | ~csr_known | (csr_ro & csr_wr_attempt));
    assign csr_rdata   = csr_illegal ? 32'd0 : csr_old;
    assign csr_we      = csr_req & instr_commit & ~take_trap & ~take_return
                       & ~csr_illegal & csr_wr_attempt;

    // Architectural state update: trap > mret > CSR write
    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        if (take_trap) begin
            mepc_d     = actual_pc & ~32'd1;
            mcause_d   = exc_valid ? {1'b0, 26'd0, exc_cause} : {1'b1, 26'd0, irq_cause};
            mtval_d    = exc_valid ? exc_tval : 32'd0;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end else if (take_return) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mst_mie_d  = csr_new[MSTATUS_MIE_BIT];
                    mst_mpie_d = csr_new[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_d      = csr_new & MIE_WMASK;
`ifdef RV32_MTVEC_VECTORED_EN
                CSR_MTVEC:    mtvec_d    = {csr_new[31:2], (csr_new[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
                CSR_MTVEC:    mtvec_d    = {csr_new[31:2], 2'b00};
`endif
                CSR_MSCRATCH: mscratch_d = csr_new;
                CSR_MEPC:     mepc_d     = csr_new & ~32'd1;
                CSR_MCAUSE:   mcause_d   = csr_new;
                CSR_MTVAL:    mtval_d    = csr_new;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= {RESET_MTVEC[31:2], 2'b00};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

    rv32_csr_counter64 u_mcycle (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_en_i (1'b1),
        .wr_lo_i  (csr_we && csr_addr == CSR_MCYCLE),
        .wr_hi_i  (csr_we && csr_addr == CSR_MCYCLEH),
        .wdata_i  (csr_new),
        .count_o  (mcycle)
    );

    rv32_csr_counter64 u_minstret (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_en_i (instr_commit & ~take_trap),
        .wr_lo_i  (csr_we && csr_addr == CSR_MINSTRET),
        .wr_hi_i  (csr_we && csr_addr == CSR_MINSTRETH),
        .wdata_i  (csr_new),
        .count_o  (minstret)
    );

endmodule

// File: tb/tb_rv32_trap_csr_unit.sv
// Directed bench for rv32_trap_csr_unit (N_LOCAL_IRQ=4, RESET_MTVEC=0x1000, HART_ID=5).
// Honours RV32_MTVEC_VECTORED_EN for the mtvec/trap_pc expectations.
module tb_rv32_trap_csr_unit;

`ifdef RV32_MTVEC_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        irq_software, irq_timer, irq_external;
    logic [3:0]  irq_local;
    logic        csr_req;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instr_commit;
    logic [31:0] actual_pc;
    logic        exc_valid;
    logic [4:0]  exc_cause;
    logic [31:0] exc_tval;
    logic        mret_commit;
    logic        take_trap;
    logic [31:0] trap_pc;
    logic        take_return;
    logic [31:0] return_pc;
    logic        irq_wake;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_instret;

    always #5 clk = ~clk;

    rv32_trap_csr_unit #(
        .N_LOCAL_IRQ (4),
        .RESET_MTVEC (32'h0000_1000),
        .HART_ID     (32'h0000_0005)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_software (irq_software),
        .irq_timer    (irq_timer),
        .irq_external (irq_external),
        .irq_local    (irq_local),
        .csr_req      (csr_req),
        .csr_op       (csr_op),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal),
        .instr_commit (instr_commit),
        .actual_pc    (actual_pc),
        .exc_valid    (exc_valid),
        .exc_cause    (exc_cause),
        .exc_tval     (exc_tval),
        .mret_commit  (mret_commit),
        .take_trap    (take_trap),
        .trap_pc      (trap_pc),
        .take_return  (take_return),
        .return_pc    (return_pc),
        .irq_wake     (irq_wake)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        csr_req      = 1'b0;
        instr_commit = 1'b0;
        exc_valid    = 1'b0;
        mret_commit  = 1'b0;
        csr_wdata    = '0;
    endtask

    // Side-effect-free read: RS with zero operand, no commit
    task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
        csr_req   = 1'b1;
        csr_op    = 2'b10;
        csr_addr  = addr;
        csr_wdata = '0;
        #1;
        chk(tag, csr_rdata, exp);
        csr_req   = 1'b0;
    endtask

    // Committed CSR instruction (assumes no trap this cycle)
    task automatic wr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data);
        csr_req      = 1'b1;
        csr_op       = op;
        csr_addr     = addr;
        csr_wdata    = data;
        instr_commit = 1'b1;
        actual_pc    = 32'h0000_0100;
        tick();
        exp_instret++;
        clear();
    endtask

    initial begin
        rst_n = 1'b0;
        irq_software = 1'b0; irq_timer = 1'b0; irq_external = 1'b0; irq_local = '0;
        csr_op = 2'b00; csr_addr = '0; actual_pc = '0; exc_cause = '0; exc_tval = '0;
        clear();
        exp_instret = '0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset state
        rd(12'h300, 32'h0000_1800, "rst_mstatus");
        rd(12'h305, 32'h0000_1000, "rst_mtvec");
        rd(12'h304, 32'h0000_0000, "rst_mie");
        rd(12'h341, 32'h0000_0000, "rst_mepc");
        rd(12'hF14, 32'h0000_0005, "mhartid");
        chk("rst_take_trap", 32'(take_trap), 32'd0);
        chk("rst_irq_wake", 32'(irq_wake), 32'd0);
        tick();
        rd(12'hB02, 32'h0000_0000, "rst_minstret");

        // Timer interrupt trap
        wr(2'b01, 12'h300, 32'h8);
        rd(12'h300, 32'h0000_1808, "mstatus_mie_set");
        wr(2'b01, 12'h304, 32'hFFFF_FFFF);
        rd(12'h304, 32'h000F_0888, "mie_wmask");
        wr(2'b01, 12'h304, 32'h80);
        irq_timer = 1'b1;
        #1;
        chk("irq_wake_timer", 32'(irq_wake), 32'd1);
        instr_commit = 1'b1; actual_pc = 32'h200;
        #1;
        chk("timer_take_trap", 32'(take_trap), 32'd1);
        chk("timer_trap_pc", trap_pc, 32'h0000_1000);
        tick(); clear();
        rd(12'h341, 32'h0000_0200, "timer_mepc");
        rd(12'h342, 32'h8000_0007, "timer_mcause");
        rd(12'h300, 32'h0000_1880, "timer_mstatus");
        rd(12'h343, 32'h0000_0000, "timer_mtval");

        // Exception beats simultaneous external+timer interrupts
        wr(2'b10, 12'h300, 32'h8);
        irq_external = 1'b1; exc_valid = 1'b1; exc_cause = 5'd2; exc_tval = 32'hDEAD_BEEF;
        instr_commit = 1'b1; actual_pc = 32'h305;
        #1;
        chk("exc_take_trap", 32'(take_trap), 32'd1);
        chk("exc_trap_pc", trap_pc, 32'h0000_1000);
        tick(); clear();
        irq_external = 1'b0; irq_timer = 1'b0;
        rd(12'h342, 32'h0000_0002, "exc_mcause");
        rd(12'h343, 32'hDEAD_BEEF, "exc_mtval");
        rd(12'h341, 32'h0000_0304, "exc_mepc_bit0");
        rd(12'hB02, exp_instret, "exc_minstret_hold");
        rd(12'h300, 32'h0000_1880, "exc_mstatus");

        // mret
        mret_commit = 1'b1; instr_commit = 1'b1; actual_pc = 32'h400;
        #1;
        chk("mret_take_return", 32'(take_return), 32'd1);
        chk("mret_return_pc", return_pc, 32'h0000_0304);
        chk("mret_no_trap", 32'(take_trap), 32'd0);
        tick(); clear();
        exp_instret++;
        rd(12'h300, 32'h0000_1888, "mret_mstatus");
        rd(12'hB02, exp_instret, "mret_minstret");

        // mret with a pending interrupt: trap only
        irq_timer = 1'b1; mret_commit = 1'b1; instr_commit = 1'b1; actual_pc = 32'h500;
        #1;
        chk("mret_irq_trap", 32'(take_trap), 32'd1);
        chk("mret_irq_no_return", 32'(take_return), 32'd0);
        tick(); clear();
        irq_timer = 1'b0;
        rd(12'h300, 32'h0000_1880, "mret_irq_mstatus");
        rd(12'h341, 32'h0000_0500, "mret_irq_mepc");

        // CSR ops on mscratch
        wr(2'b01, 12'h340, 32'h0F);
        csr_req = 1'b1; csr_op = 2'b10; csr_addr = 12'h340; csr_wdata = 32'hF0; instr_commit = 1'b1;
        #1;
        chk("rs_old_rdata", csr_rdata, 32'h0000_000F);
        chk("rs_legal", 32'(csr_illegal), 32'd0);
        tick(); clear();
        exp_instret++;
        rd(12'h340, 32'h0000_00FF, "rs_result");
        wr(2'b11, 12'h340, 32'h0F);
        rd(12'h340, 32'h0000_00F0, "rc_result");

        // Illegal accesses
        irq_software = 1'b1;
        csr_req = 1'b1; csr_op = 2'b01; csr_addr = 12'h344; csr_wdata = 32'h0; instr_commit = 1'b1;
        #1;
        chk("mip_rw_illegal", 32'(csr_illegal), 32'd1);
        chk("mip_rw_rdata0", csr_rdata, 32'd0);
        tick(); clear();
        exp_instret++;
        csr_req = 1'b1; csr_op = 2'b10; csr_addr = 12'h344; csr_wdata = 32'h0;
        #1;
        chk("mip_rs0_legal", 32'(csr_illegal), 32'd0);
        chk("mip_live", csr_rdata, 32'h0000_0008);
        csr_op = 2'b11; csr_wdata = 32'h1;
        #1;
        chk("mip_rc_illegal", 32'(csr_illegal), 32'd1);
        csr_op = 2'b01; csr_addr = 12'h7C0;
        #1;
        chk("unknown_illegal", 32'(csr_illegal), 32'd1);
        csr_op = 2'b01; csr_addr = 12'hF14;
        #1;
        chk("mhartid_wr_illegal", 32'(csr_illegal), 32'd1);
        clear();
        irq_software = 1'b0;
        tick();
        csr_req = 1'b1; csr_op = 2'b00; csr_addr = 12'h340; csr_wdata = 32'h1234; instr_commit = 1'b1;
        #1;
        chk("op00_illegal", 32'(csr_illegal), 32'd1);
        tick(); clear();
        exp_instret++;
        rd(12'h340, 32'h0000_00F0, "op00_no_write");

        // mcycle wrap
        wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        wr(2'b01, 12'hB80, 32'hFFFF_FFFF);
        rd(12'hB00, 32'hFFFF_FFFF, "mcycle_lo_max");
        rd(12'hB80, 32'hFFFF_FFFF, "mcycle_hi_max");
        tick();
        rd(12'hB00, 32'h0000_0000, "mcycle_lo_wrap");
        rd(12'hB80, 32'h0000_0000, "mcycle_hi_wrap");
        tick();
        rd(12'hB00, 32'h0000_0001, "mcycle_after_wrap");

        // minstret write replaces the increment
        wr(2'b01, 12'hB02, 32'h10);
        exp_instret = 32'h10;
        rd(12'hB02, exp_instret, "minstret_wr");
        rd(12'hB82, 32'h0, "minstret_hi");

        // Reset mid-count
        wr(2'b01, 12'h340, 32'hAA);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rd(12'hB00, 32'h0, "rst_mcycle");
        rd(12'hB02, 32'h0, "rst_minstret2");
        rd(12'h340, 32'h0, "rst_mscratch");
        rd(12'h300, 32'h0000_1800, "rst_mstatus2");
        rd(12'h305, 32'h0000_1000, "rst_mtvec2");
        tick();
        rd(12'hB00, 32'h0, "rst_mcycle_hold");
        rst_n = 1'b1;
        exp_instret = '0;

        // mtvec mode and local interrupt vectoring
        wr(2'b01, 12'h305, 32'h2001);
        rd(12'h305, VEC ? 32'h2001 : 32'h2000, "mtvec_mode");
        wr(2'b01, 12'h304, 32'h0001_0000);
        wr(2'b10, 12'h300, 32'h8);
        irq_local = 4'b0001; instr_commit = 1'b1; actual_pc = 32'h600;
        #1;
        chk("local0_take_trap", 32'(take_trap), 32'd1);
        chk("local0_trap_pc", trap_pc, VEC ? 32'h2040 : 32'h2000);
        tick(); clear();
        irq_local = '0;
        rd(12'h342, 32'h8000_0010, "local0_mcause");
        rd(12'hB02, exp_instret, "local0_minstret");

        // Exception targets the base even in vectored mode
        wr(2'b10, 12'h300, 32'h8);
        exc_valid = 1'b1; exc_cause = 5'd11; exc_tval = 32'h0; instr_commit = 1'b1;
        #1;
        chk("ecall_trap_pc", trap_pc, 32'h2000);
        tick(); clear();

        // Local interrupt ordering, then software over locals
        wr(2'b01, 12'h304, 32'hFFFF_FFFF);
        wr(2'b10, 12'h300, 32'h8);
        irq_local = 4'b0110; instr_commit = 1'b1;
        #1;
        chk("local1_trap_pc", trap_pc, VEC ? 32'h2044 : 32'h2000);
        tick(); clear();
        rd(12'h342, 32'h8000_0011, "local1_mcause");
        irq_local = '0;
        wr(2'b10, 12'h300, 32'h8);
        irq_local = 4'b0110; irq_software = 1'b1; instr_commit = 1'b1;
        #1;
        chk("msi_trap_pc", trap_pc, VEC ? 32'h200C : 32'h2000);
        tick(); clear();
        irq_local = '0; irq_software = 1'b0;
        rd(12'h342, 32'h8000_0003, "msi_mcause");

        // MODE 1x is never stored
        wr(2'b01, 12'h305, 32'h3003);
        rd(12'h305, 32'h3000, "mtvec_mode_1x");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
